note_select: RTL and testbench

Upstream stage of the flute display pipeline. It turns the eight raw flute-key inputs into the one-hot picture-select vector `sw` consumed by the 160×120 pixel scanner. Each key is synchronised and debounced, and the lowest-numbered held key wins. The selection is committed only at the last pixel of a frame, so the scanner never switches pictures mid-frame.

---
 rtl/flute_pkg.sv | 37 +++
 rtl/key_debounce.sv | 41 ++++
 rtl/note_select.sv | 59 +++++
 tb/tb_note_select.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/flute_pkg.sv
// Constants shared by the flute display pipeline (note selection and pixel scanner),
// plus the one-hot helpers used to build the picture-select vector.
package flute_pkg;

  localparam int FRAME_W     = 160;
  localparam int FRAME_H     = 120;
  localparam int NUM_NOTES   = 8;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int NOTE_CODE_W = $clog2(NUM_NOTES);

  // One-hot of the lowest set bit; zero when no bit is set.
  function automatic logic [NUM_NOTES-1:0] lowest_set(input logic [NUM_NOTES-1:0] v);
    logic [NUM_NOTES-1:0] res;
    logic                 found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (v[i] && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  // OR of the indices of set bits; only meaningful for one-hot or zero input.
  function automatic logic [NOTE_CODE_W-1:0] onehot_to_code(input logic [NUM_NOTES-1:0] v);
    logic [NOTE_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (v[i]) code = code | NOTE_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One flute key: two-flop synchroniser followed by a counter that accepts a new
// level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], key_raw};
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign key_stable = r_stable;

endmodule

// File: rtl/note_select.sv
// Debounces the eight flute keys, picks the lowest-numbered held key and commits
// it to the picture-select vector only at the last pixel of a frame.
module note_select
  import flute_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic [NUM_NOTES-1:0]   key_raw,
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  output logic [NUM_NOTES-1:0]   sw,
  output logic [NOTE_CODE_W-1:0] note_code,
  output logic                   note_active,
  output logic                   note_changed
);

  logic [NUM_NOTES-1:0] w_stable;
  logic [NUM_NOTES-1:0] w_pending;
  logic                 w_frame_end;
  logic [NUM_NOTES-1:0] r_sw;
  logic                 r_changed;

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .key_raw   (key_raw[g]),
      .key_stable(w_stable[g])
    );
  end

  assign w_pending   = lowest_set(w_stable);
  // Exact compare: out-of-range scanner coordinates can never trigger a commit.
  assign w_frame_end = (x == X_W'(FRAME_W - 1)) && (y == Y_W'(FRAME_H - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sw      <= '0;
      r_changed <= 1'b0;
    end else if (w_frame_end) begin
      r_sw      <= w_pending;
      r_changed <= (w_pending != r_sw);
    end else begin
      r_changed <= 1'b0;
    end
  end

  assign sw           = r_sw;
  assign note_code    = onehot_to_code(r_sw);
  assign note_active  = |r_sw;
  assign note_changed = r_changed;

endmodule

// File: tb/tb_note_select.sv
// Randomised scoreboard bench for note_select with a fast-forward scanner and a
// key-history reference model.
module tb_note_select;
  import flute_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] key_raw;
  logic [7:0] x;
  logic [6:0] y;
  logic [7:0] sw;
  logic [2:0] note_code;
  logic       note_active;
  logic       note_changed;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] sw;
    logic       changed;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  note_select #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (2)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .key_raw     (key_raw),
    .x           (x),
    .y           (y),
    .sw          (sw),
    .note_code   (note_code),
    .note_active (note_active),
    .note_changed(note_changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key is accepted once the last DEB synchronised samples all
  // disagree with the accepted level; a commit takes the lowest accepted key.
  logic [7:0]     m_s1, m_s2, m_stable, m_sw;
  logic [DEB-1:0] m_hist [8];

  task automatic model_clear();
    m_s1     = '0;
    m_s2     = '0;
    m_stable = '0;
    m_sw     = '0;
    for (int i = 0; i < 8; i++) m_hist[i] = '0;
    sb.delete();
  endtask

  initial begin
    exp_t e;
    model_clear();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        model_clear();
      end else begin
        if (x == 8'(FRAME_W - 1) && y == 7'(FRAME_H - 1)) begin
          e.sw      = m_stable & (~m_stable + 8'd1);
          e.changed = (e.sw != m_sw);
          m_sw      = e.sw;
          sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
          m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
          if (m_hist[i] == {DEB{~m_stable[i]}}) m_stable[i] = ~m_stable[i];
        end
        m_s2 = m_s1;
        m_s1 = key_raw;
      end
    end
  end

  // Monitor: pops an expectation on every commit, otherwise checks the hold.
  initial begin
    exp_t       e;
    logic [7:0] last_sw;
    last_sw = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last_sw = '0;
        check("reset_sw", 32'(sw), 32'h0);
        check("reset_changed", 32'(note_changed), 32'h0);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        last_sw = e.sw;
        check("commit_sw", 32'(sw), 32'(e.sw));
        check("commit_code", 32'(note_code), 32'($clog2(e.sw)));
        check("commit_active", 32'(note_active), 32'(e.sw != 0));
        check("commit_changed", 32'(note_changed), 32'(e.changed));
      end else begin
        check("hold_sw", 32'(sw), 32'(last_sw));
        check("hold_changed", 32'(note_changed), 32'h0);
      end
    end
  end

  // Compressed scanner: a few in/out-of-range positions per frame, ending at (159,119).
  int fpos = 0;
  int flen = 8;

  task automatic scan_next();
    if (fpos >= flen - 1) begin
      x    = 8'd159;
      y    = 7'd119;
      fpos = 0;
      flen = $urandom_range(6, 14);
    end else begin
      fpos++;
      case ($urandom_range(0, 9))
        0:       begin x = 8'd160; y = 7'd119; end
        1:       begin x = 8'd159; y = 7'd120; end
        2:       begin x = 8'd255; y = 7'd127; end
        3:       begin x = 8'd50;  y = 7'd60;  end
        4:       begin x = 8'd159; y = 7'($urandom_range(0, 118)); end
        5:       begin x = 8'($urandom_range(0, 158)); y = 7'd119; end
        default: begin x = 8'($urandom_range(0, 158)); y = 7'($urandom_range(0, 119)); end
      endcase
    end
  endtask

  task automatic cycle(input logic [7:0] raw);
    @(posedge clk);
    #1;
    key_raw = raw;
    scan_next();
  endtask

  task automatic hold(input logic [7:0] raw, input int n);
    for (int i = 0; i < n; i++) cycle(raw);
  endtask

  task automatic pulse_reset_and_check(input int n);
    resetn = 1'b0;
    #1;
    check("async_sw", 32'(sw), 32'h0);
    check("async_code", 32'(note_code), 32'h0);
    check("async_active", 32'(note_active), 32'h0);
    check("async_changed", 32'(note_changed), 32'h0);
    hold(key_raw, n);
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] rk;
    int         len;
    resetn  = 1'b0;
    key_raw = '0;
    x       = '0;
    y       = '0;
    hold(8'h00, 3);
    resetn = 1'b1;

    // Reset mid-run with a committed note, then release with no keys.
    hold(8'h10, 30);
    check("pre_reset_sw", 32'(sw), 32'h10);
    pulse_reset_and_check(3);
    hold(8'h00, 30);
    check("post_reset_sw", 32'(sw), 32'h0);

    // Single key.
    hold(8'h04, 40);
    check("single_sw", 32'(sw), 32'h04);
    check("single_code", 32'(note_code), 32'd2);
    hold(8'h00, 40);

    // Glitch shorter than the debounce window, then a bouncing press.
    hold(8'h02, 3);
    hold(8'h00, 30);
    check("glitch_sw", 32'(sw), 32'h0);
    cycle(8'h02); cycle(8'h02); cycle(8'h00);
    hold(8'h02, 30);
    check("bounce_sw", 32'(sw), 32'h02);
    hold(8'h00, 40);

    // Priority, then release of the winning key.
    hold(8'h0A, 40);
    check("prio_sw", 32'(sw), 32'h02);
    check("prio_code", 32'(note_code), 32'd1);
    hold(8'h08, 40);
    check("prio_rel_sw", 32'(sw), 32'h08);
    check("prio_rel_code", 32'(note_code), 32'd3);
    hold(8'h00, 40);

    // Reset while the debounce counter is part-way.
    hold(8'h20, 5);
    pulse_reset_and_check(2);
    hold(8'h20, 40);
    check("mid_deb_sw", 32'(sw), 32'h20);
    hold(8'h00, 40);

    // Random bursts of sparse key patterns with occasional resets.
    for (int n = 0; n < 150; n++) begin
      rk  = 8'($urandom & $urandom & $urandom);
      len = $urandom_range(1, 12);
      hold(rk, len);
      if ($urandom_range(0, 39) == 0) pulse_reset_and_check($urandom_range(1, 3));
    end
    hold(8'h00, 40);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
